// File: rtl/gx4000_printer_ctrl.sv
// Purpose : buffers CPU-written bytes and hands them to a parallel printer with a strobe/ack handshake.
// Latency : a byte written into an empty FIFO with the printer idle is popped 1 cycle later;
//           the strobe rises SETUP_CYC cycles after the pop and stays high for STROBE_CYC cycles.
// Backpr. : no stall towards the CPU; a write into a full FIFO is dropped and flagged in overflow.
//           Printer backpressure is honoured through printer_busy (sampled in IDLE) and printer_ack.
// Ports   : clk_sys/reset_n         clock and async active-low reset
//           wr_en/wr_data           one-cycle byte push from the CPU port decode
//           clr_flags               clears the sticky overflow/timeout flags
//           printer_busy/ack        printer status inputs, synchronous to clk_sys
//           printer_data/strobe     registered printer outputs
//           fifo_empty/fifo_full    FIFO occupancy status
//           ctrl_busy               handshake FSM is not IDLE
//           overflow/timeout        sticky error flags
module gx4000_printer_ctrl #(
   parameter int FIFO_DEPTH  = 4,
   parameter int SETUP_CYC   = 2,
   parameter int STROBE_CYC  = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       clr_flags,
   input  logic       printer_busy,
   input  logic       printer_ack,
   output logic [7:0] printer_data,
   output logic       printer_strobe,
   output logic       fifo_empty,
   output logic       fifo_full,
   output logic       ctrl_busy,
   output logic       overflow,
   output logic       timeout
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
   // Counters compare against "last cycle" values so a phase lasts exactly N cycles.
   localparam logic [15:0]   SETUP_LAST   = 16'(SETUP_CYC - 1);
   localparam logic [15:0]   STROBE_LAST  = 16'(STROBE_CYC - 1);
   localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      STROBE   = 2'd2,
      WAIT_ACK = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [15:0]     cnt;
   logic [15:0]     cnt_nxt;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   logic            full_now;
   logic            push;
   logic            pop;
   logic            ovf_set;
   logic            tmo_set;

   // Fullness is judged on the registered count, before any same-cycle pop,
   // so a write into a full FIFO is dropped even if IDLE pops at this edge.
   assign full_now = (count == DEPTH_C);
   assign push     = wr_en && !full_now;
   assign ovf_set  = wr_en && full_now;

   // Status outputs decode registered state only.
   assign fifo_empty = (count == '0);
   assign fifo_full  = full_now;
   assign ctrl_busy  = (state != IDLE);

   // ---------------------------------------------------------------
   // Handshake FSM: next-state, phase counter, pop and timeout events
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pop       = 1'b0;
      tmo_set   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if ((count != '0) && !printer_busy) begin
               pop       = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (cnt == SETUP_LAST) begin
               cnt_nxt   = '0;
               state_nxt = STROBE;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         STROBE: begin
            if (cnt == STROBE_LAST) begin
               cnt_nxt   = '0;
               state_nxt = WAIT_ACK;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         WAIT_ACK: begin
            // An ack on the expiry cycle wins: the byte counts as delivered.
            if (printer_ack) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else if (cnt == TIMEOUT_LAST) begin
               cnt_nxt   = '0;
               tmo_set   = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         cnt            <= '0;
         printer_strobe <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         // Strobe flop follows the state being entered, so it is high
         // exactly for the cycles the FSM spends in STROBE.
         printer_strobe <= (state_nxt == STROBE);
      end
   end

   // ---------------------------------------------------------------
   // FIFO storage and pointers
   // ---------------------------------------------------------------
   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk_sys) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointer width equals log2(depth), so the increment wraps naturally.
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // printer_data is loaded only on a pop and holds until the next one.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         printer_data <= 8'h00;
      end else if (pop) begin
         printer_data <= mem[rd_ptr];
      end
   end

   // ---------------------------------------------------------------
   // Sticky flags: a set event in the same cycle beats clr_flags
   // ---------------------------------------------------------------
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clr_flags) begin
            overflow <= 1'b0;
         end
         if (tmo_set) begin
            timeout <= 1'b1;
         end else if (clr_flags) begin
            timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gx4000_printer_ctrl.sv
// Purpose : self-checking bench for gx4000_printer_ctrl; directed scenarios plus random traffic
//           compared every cycle against a transaction-level reference model.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_gx4000_printer_ctrl;

   localparam int D  = 4;
   localparam int S  = 2;
   localparam int ST = 4;
   localparam int TO = 16;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       clr_flags;
   logic       printer_busy;
   logic       printer_ack;
   logic [7:0] printer_data;
   logic       printer_strobe;
   logic       fifo_empty;
   logic       fifo_full;
   logic       ctrl_busy;
   logic       overflow;
   logic       timeout;

   int n_checks = 0;
   int n_pass   = 0;

   gx4000_printer_ctrl #(
      .FIFO_DEPTH (D),
      .SETUP_CYC  (S),
      .STROBE_CYC (ST),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .clr_flags     (clr_flags),
      .printer_busy  (printer_busy),
      .printer_ack   (printer_ack),
      .printer_data  (printer_data),
      .printer_strobe(printer_strobe),
      .fifo_empty    (fifo_empty),
      .fifo_full     (fifo_full),
      .ctrl_busy     (ctrl_busy),
      .overflow      (overflow),
      .timeout       (timeout)
   );

   always #5 clk_sys = ~clk_sys;

   // Reference model: a byte queue plus "cycles since the byte was popped".
   // The transfer phase follows from that elapsed time by plain arithmetic.
   logic [7:0] mq[$];
   bit         m_xfer;
   int         m_t;
   logic [7:0] m_data;
   bit         m_ovf;
   bit         m_tmo;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      mq.delete();
      m_xfer = 0;
      m_t    = 0;
      m_data = 8'h00;
      m_ovf  = 0;
      m_tmo  = 0;
   endtask

   task automatic model_edge(input logic w, input logic [7:0] d, input logic c,
                             input logic b, input logic a);
      bit full_before;
      bit pop_now;
      bit ovf_set;
      bit tmo_set;
      full_before = (mq.size() == D);
      pop_now     = !m_xfer && (mq.size() > 0) && !b;
      ovf_set     = w && full_before;
      tmo_set     = 0;
      if (m_xfer) begin
         if (m_t >= S + ST) begin
            if (a) m_xfer = 0;
            else if (m_t - (S + ST) == TO - 1) begin
               m_xfer  = 0;
               tmo_set = 1;
            end
         end
         m_t++;
      end
      if (pop_now) begin
         m_data = mq.pop_front();
         m_xfer = 1;
         m_t    = 0;
      end
      if (w && !full_before) mq.push_back(d);
      if (ovf_set) m_ovf = 1; else if (c) m_ovf = 0;
      if (tmo_set) m_tmo = 1; else if (c) m_tmo = 0;
   endtask

   task automatic compare_all();
      chk("printer_data",   32'(printer_data),   32'(m_data));
      chk("printer_strobe", 32'(printer_strobe), 32'(m_xfer && m_t >= S && m_t < S + ST));
      chk("fifo_empty",     32'(fifo_empty),     32'(mq.size() == 0));
      chk("fifo_full",      32'(fifo_full),      32'(mq.size() == D));
      chk("ctrl_busy",      32'(ctrl_busy),      32'(m_xfer));
      chk("overflow",       32'(overflow),       32'(m_ovf));
      chk("timeout",        32'(timeout),        32'(m_tmo));
   endtask

   // Called at posedge+1 or later: drive, take one edge, update model, compare.
   task automatic step(input logic w, input logic [7:0] d, input logic c,
                       input logic b, input logic a);
      wr_en = w; wr_data = d; clr_flags = c; printer_busy = b; printer_ack = a;
      @(posedge clk_sys);
      model_edge(w, d, c, b, a);
      #1;
      compare_all();
   endtask

   // Asserts reset between edges, checks the asynchronous effect, then releases.
   task automatic async_reset();
      #2;
      reset_n = 1'b0;
      wr_en = 0; clr_flags = 0; printer_busy = 0; printer_ack = 0;
      #1;
      model_reset();
      compare_all();
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int         n_strobe;
      bit         prev_stb;
      logic [7:0] got[$];
      reset_n = 1'b0;
      wr_en = 0; wr_data = 8'h00; clr_flags = 0; printer_busy = 0; printer_ack = 0;
      model_reset();
      #1;
      compare_all();
      chk("rst_empty", 32'(fifo_empty), 32'd1);
      @(posedge clk_sys);
      #1;
      reset_n = 1'b1;

      // Single byte: pop at edge 1, strobe over edges 3..6, ack seen at edge 10.
      step(1, 8'h41, 0, 0, 0);
      for (int e = 1; e <= 10; e++) begin
         step(0, 8'h00, 0, 0, (e == 10));
         if (e == 1) chk("e1_data", 32'(printer_data), 32'h41);
         chk("e_strobe", 32'(printer_strobe), 32'(e >= 3 && e <= 6));
         chk("e_busy",   32'(ctrl_busy),      32'(e < 10));
      end

      // Five writes while printer busy: 4 stored, 5th dropped, order preserved.
      for (int i = 1; i <= 5; i++) begin
         step(1, 8'(i), 0, 1, 0);
         if (i == 4) chk("full_after4", 32'(fifo_full), 32'd1);
      end
      chk("ovf_after5", 32'(overflow), 32'd1);
      prev_stb = 0;
      for (int i = 0; i < 60; i++) begin
         step(0, 8'h00, 0, 0, 1);
         if (printer_strobe && !prev_stb) got.push_back(printer_data);
         prev_stb = printer_strobe;
      end
      chk("order_len", 32'(got.size()), 32'd4);
      for (int i = 0; i < got.size() && i < 4; i++) chk("order_byte", 32'(got[i]), 32'(i + 1));

      // Full FIFO with simultaneous pop and write: write dropped.
      step(0, 8'h00, 1, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 8'h80 + 8'(i), 0, 1, 0);
      step(1, 8'hEE, 0, 0, 0);
      chk("popwr_ovf",  32'(overflow),  32'd1);
      chk("popwr_full", 32'(fifo_full), 32'd0);
      for (int i = 0; i < 50; i++) step(0, 8'h00, 1, 0, 1);

      // Ack timeout: byte A written at edge 0, times out after edge 23, B pops at 24.
      step(1, 8'hA5, 0, 0, 0);
      for (int e = 1; e <= 25; e++) begin
         step((e == 1), 8'hB6, (e == 25), 0, 0);
         if (e >= 2 && e <= 24) chk("tmo_flag", 32'(timeout), 32'(e >= 23));
         if (e == 24) begin
            chk("tmo_next_busy", 32'(ctrl_busy), 32'd1);
            chk("tmo_next_data", 32'(printer_data), 32'hB6);
         end
         if (e == 25) chk("tmo_clr", 32'(timeout), 32'd0);
      end
      for (int i = 0; i < 30; i++) step(0, 8'h00, 1, 0, 1);

      // Reset during STROBE with three bytes queued.
      for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 0, 0, 0);
      n_strobe = 0;
      while (!printer_strobe && n_strobe < 20) begin
         step(0, 8'h00, 0, 0, 0);
         n_strobe++;
      end
      chk("rst_strobe_seen", 32'(printer_strobe), 32'd1);
      async_reset();
      chk("rst_mid_strobe", 32'(printer_strobe), 32'd0);
      chk("rst_mid_empty",  32'(fifo_empty),     32'd1);
      n_strobe = 0;
      for (int i = 0; i < 30; i++) begin
         step(0, 8'h00, 0, $urandom_range(0, 1), $urandom_range(0, 1));
         if (printer_strobe) n_strobe++;
      end
      chk("rst_no_strobe", 32'(n_strobe), 32'd0);

      // Random traffic: busy toggles and stray acks in every state, occasional reset.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) < 30), 8'($urandom), ($urandom_range(0, 99) < 5),
              ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 8));
         if ($urandom_range(0, 499) == 0) async_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
